// File: rtl/nn_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word RAM, with a
// bounded bus lock for port 1 and range-checked error responses.

module nn_mem_arb_port #(
    parameter int RAM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [31:0]   addr,
    input  logic          we,
    input  logic          gnt,
    input  logic [31:0]   ram_rdata,
    output logic          legal,
    output logic [AW-1:0] word,
    output logic          rvalid,
    output logic [31:0]   rdata,
    output logic          err
);
    logic vld_q, err_q, rd_q;

    assign legal = (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(RAM_WORDS));
    assign word  = addr[AW+1:2];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            vld_q <= gnt;
            err_q <= gnt & ~legal;
            rd_q  <= gnt & legal & ~we;
        end
    end

    // Response side is masked during reset so a stale response never leaks out.
    assign rvalid = RST_N & vld_q;
    assign err    = RST_N & vld_q & err_q;
    assign rdata  = (RST_N & vld_q & rd_q) ? ram_rdata : 32'h0;
endmodule

module nn_mem_arbiter #(
    parameter int RAM_WORDS = 1024,
    parameter int AW        = 10,
    parameter int LOCK_MAX  = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    input  logic          m1_lock,
    output logic          lock_abort,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);
    localparam int NUM_LANES = 2;
    localparam int CW        = $clog2(LOCK_MAX) + 1;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state;
    logic          last_gnt;
    logic          lock_armed;
    logic [CW-1:0] lock_cnt;
    logic          lock_end;
    logic          sel;

    logic [NUM_LANES-1:0]           req, we, gnt, legal, rvalid, err;
    logic [NUM_LANES-1:0][31:0]     addr, wdata, rdata;
    logic [NUM_LANES-1:0][AW-1:0]   word;

    assign req   = {m1_req, m0_req};
    assign we    = {m1_we, m0_we};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};

    assign lock_end = (lock_cnt == CW'(LOCK_MAX - 1));

    always_comb begin
        gnt = '0;
        if (RST_N) begin
            if (state == ST_LOCKED) begin
                // Dropping m1_lock releases the bus without a grant that cycle.
                if (m1_lock) gnt[1] = req[1];
            end else if (&req) begin
                gnt = last_gnt ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    assign lock_abort = RST_N && (state == ST_LOCKED) && m1_lock && lock_end;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        nn_mem_arb_port #(.RAM_WORDS(RAM_WORDS), .AW(AW)) u_port (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .addr      (addr[i]),
            .we        (we[i]),
            .gnt       (gnt[i]),
            .ram_rdata (ram_rdata),
            .legal     (legal[i]),
            .word      (word[i]),
            .rvalid    (rvalid[i]),
            .rdata     (rdata[i]),
            .err       (err[i])
        );
    end

    assign sel       = gnt[1];
    assign ram_en    = |(gnt & legal);
    assign ram_we    = ram_en & we[sel];
    assign ram_addr  = word[sel];
    assign ram_wdata = wdata[sel];

    assign {m1_gnt, m0_gnt}       = gnt;
    assign {m1_rvalid, m0_rvalid} = rvalid;
    assign {m1_err, m0_err}       = err;
    assign m0_rdata               = rdata[0];
    assign m1_rdata               = rdata[1];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_ARB;
            last_gnt   <= 1'b1;
            lock_cnt   <= '0;
            lock_armed <= 1'b1;
        end else begin
            if (gnt[0]) last_gnt <= 1'b0;
            if (gnt[1]) last_gnt <= 1'b1;
            if (!m1_lock) lock_armed <= 1'b1;
            if (state == ST_ARB) begin
                if (gnt[1] && m1_lock && lock_armed) begin
                    state    <= ST_LOCKED;
                    lock_cnt <= '0;
                end
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
                if (!m1_lock) begin
                    state <= ST_ARB;
                end else if (lock_end) begin
                    // Forced release: hand the next tie to M0 and refuse re-lock
                    // until M1 lets go of m1_lock for a cycle.
                    state      <= ST_ARB;
                    last_gnt   <= 1'b1;
                    lock_armed <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Bench for nn_mem_arbiter: behavioural RAM/arbiter model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_nn_mem_arbiter;
    localparam int RAM_WORDS = 1024;
    localparam int AW        = 10;
    localparam int LOCK_MAX  = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0]   m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          lock_abort, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    nn_mem_arbiter #(.RAM_WORDS(RAM_WORDS), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .m1_lock(m1_lock), .lock_abort(lock_abort),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM macro with 1-cycle registered read
    logic [31:0] ram [RAM_WORDS];
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: ownership, tie preference, lock bookkeeping, memory image
    logic [31:0] mmem [RAM_WORDS];
    bit          m_locked, m_armed, m_tie1;
    int          m_held;
    bit   [1:0]  p_v, p_e;
    logic [31:0] p_d [2];
    bit   [1:0]  e_g, r_now;
    bit          e_ab, e_en, e_we, e_legal, e_wr;
    int          e_s;
    logic [31:0] e_a;

    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("reset_ctrl", 32'({m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid,
                                   m0_err, m1_err, lock_abort}), 32'h0);
            chk("reset_rdata", m0_rdata | m1_rdata, 32'h0);
            m_locked = 0; m_armed = 1; m_tie1 = 0; m_held = 0; p_v = 0; p_e = 0;
        end else begin
            r_now = {m1_req, m0_req};
            e_g = 2'b00;
            if (m_locked) begin
                if (m1_lock) e_g[1] = r_now[1];
            end else if (r_now == 2'b11) begin
                e_g = m_tie1 ? 2'b10 : 2'b01;
            end else begin
                e_g = r_now;
            end
            e_ab = m_locked && m1_lock && (m_held == LOCK_MAX - 1);
            chk("gnt", 32'({m1_gnt, m0_gnt}), 32'(e_g));
            chk("lock_abort", 32'(lock_abort), 32'(e_ab));
            chk("m0_rsp", 32'({m0_rvalid, m0_err}), 32'({p_v[0], p_e[0]}));
            chk("m1_rsp", 32'({m1_rvalid, m1_err}), 32'({p_v[1], p_e[1]}));
            chk("m0_rdata", m0_rdata, p_v[0] ? p_d[0] : 32'h0);
            chk("m1_rdata", m1_rdata, p_v[1] ? p_d[1] : 32'h0);
            e_en = 0; e_we = 0; e_legal = 0; e_s = 0; e_a = 0; e_wr = 0;
            if (e_g != 2'b00) begin
                e_s     = e_g[1] ? 1 : 0;
                e_a     = e_s ? m1_addr : m0_addr;
                e_wr    = e_s ? m1_we : m0_we;
                e_legal = (e_a[1:0] == 2'b00) && (e_a[31:2] < RAM_WORDS);
                e_en    = e_legal;
                e_we    = e_legal && e_wr;
            end
            chk("ram_en_we", 32'({ram_en, ram_we}), 32'({e_en, e_we}));
            if (e_en) chk("ram_addr", 32'(ram_addr), 32'(e_a[AW+1:2]));
            if (e_we) chk("ram_wdata", ram_wdata, e_s ? m1_wdata : m0_wdata);
            for (int i = 0; i < 2; i++) begin
                p_v[i] = e_g[i];
                p_e[i] = e_g[i] && !e_legal;
                p_d[i] = (e_g[i] && e_legal && !e_wr) ? mmem[e_a[AW+1:2]] : 32'h0;
            end
            if (e_we) mmem[e_a[AW+1:2]] = e_s ? m1_wdata : m0_wdata;
            if (e_g != 2'b00) m_tie1 = (e_s == 0);
            if (m_locked) begin
                if (!m1_lock) m_locked = 0;
                else if (m_held == LOCK_MAX - 1) begin
                    m_locked = 0; m_armed = 0; m_tie1 = 0;
                end else m_held++;
            end else if (e_g[1] && m1_lock && m_armed) begin
                m_locked = 1; m_held = 0;
            end
            if (!m1_lock) m_armed = 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    task automatic do_reset(input int n);
        RST_N = 0;
        idle_inputs();
        repeat (n) tick();
        RST_N = 1;
    endtask

    task automatic acc(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output bit g_en, output bit g_we, output logic [AW-1:0] g_addr,
                       output bit r_v, output logic [31:0] r_d, output bit r_e);
        bit got;
        got = 0; g_en = 0; g_we = 0; g_addr = '0;
        if (p == 0) begin m0_req = 1; m0_we = w; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = 1; m1_we = w; m1_addr = a; m1_wdata = d; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            if ((p == 0) ? m0_gnt : m1_gnt) begin
                got = 1; g_en = ram_en; g_we = ram_we; g_addr = ram_addr;
            end
            tick();
        end
        m0_req = 0; m1_req = 0;
        chk("acc_granted", 32'(got), 32'h1);
        @(negedge CLK);
        r_v = (p == 0) ? m0_rvalid : m1_rvalid;
        r_d = (p == 0) ? m0_rdata  : m1_rdata;
        r_e = (p == 0) ? m0_err    : m1_err;
        tick();
    endtask

    bit          g_en, g_we, r_v, r_e;
    logic [AW-1:0] g_addr;
    logic [31:0] r_d;
    bit          g0 [32];
    bit          g1 [32];
    bit          ab [32];
    int          n_ab, ab_idx, starve, first_m0, rv_cnt;

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) begin
            ram[i]  = 32'h1000_0000 + 32'(i);
            mmem[i] = 32'h1000_0000 + 32'(i);
        end
        ram[5] = 32'hDEADBEEF; mmem[5] = 32'hDEADBEEF;
        ram[0] = 32'hA5A5A5A5; mmem[0] = 32'hA5A5A5A5;

        do_reset(3);

        // single read of word 5
        acc(0, 0, 32'h14, 0, g_en, g_we, g_addr, r_v, r_d, r_e);
        chk("rd5_en", 32'(g_en), 32'h1);
        chk("rd5_addr", 32'(g_addr), 32'd5);
        chk("rd5_rvalid", 32'(r_v), 32'h1);
        chk("rd5_rdata", r_d, 32'hDEADBEEF);
        chk("rd5_err", 32'(r_e), 32'h0);

        // M1 write then M0 read-back of word 16
        acc(1, 1, 32'h40, 32'h1234, g_en, g_we, g_addr, r_v, r_d, r_e);
        chk("wr16_we", 32'(g_we), 32'h1);
        chk("wr16_addr", 32'(g_addr), 32'd16);
        chk("wr16_rsp", 32'({r_v, r_e}), 32'b10);
        chk("wr16_rdata", r_d, 32'h0);
        acc(0, 0, 32'h40, 0, g_en, g_we, g_addr, r_v, r_d, r_e);
        chk("rb16_rdata", r_d, 32'h0000_1234);

        // illegal accesses and range edges
        acc(0, 0, 32'h8000_0004, 0, g_en, g_we, g_addr, r_v, r_d, r_e);
        chk("oor_en", 32'(g_en), 32'h0);
        chk("oor_rsp", 32'({r_v, r_e}), 32'b11);
        chk("oor_rdata", r_d, 32'h0);
        acc(0, 1, 32'h2, 32'hFFFF, g_en, g_we, g_addr, r_v, r_d, r_e);
        chk("mis_en", 32'(g_en), 32'h0);
        chk("mis_rsp", 32'({r_v, r_e}), 32'b11);
        chk("mis_ram0", ram[0], 32'hA5A5A5A5);
        acc(0, 0, 32'hFFC, 0, g_en, g_we, g_addr, r_v, r_d, r_e);
        chk("top_word", {r_d[31:1], r_e}, {31'h0800_01FF, 1'b0});
        acc(1, 0, 32'h1000, 0, g_en, g_we, g_addr, r_v, r_d, r_e);
        chk("past_end", 32'({g_en, r_v, r_e}), 32'b011);

        // both requesters streaming reads after reset: strict alternation from M0
        do_reset(2);
        m0_req = 1; m0_we = 0; m0_addr = 32'h8;
        m1_req = 1; m1_we = 0; m1_addr = 32'hC;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            g0[c] = m0_gnt; g1[c] = m1_gnt;
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 8; c++)
            chk("rr_seq", 32'({g1[c], g0[c]}), (c % 2 == 0) ? 32'b01 : 32'b10);

        // bus lock with forced release, no re-lock until m1_lock drops
        do_reset(2);
        for (int c = 0; c < 32; c++) begin
            m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
            m1_lock = !(c == 24 || c == 30);
            @(negedge CLK);
            g0[c] = m0_gnt; g1[c] = m1_gnt; ab[c] = lock_abort;
            tick();
        end
        idle_inputs();
        n_ab = 0; ab_idx = -1; starve = 0; first_m0 = -1;
        for (int c = 0; c < 32; c++) begin
            if (ab[c]) begin n_ab++; ab_idx = c; end
            if (c >= 2 && c <= 17 && !g0[c]) starve++;
            if (c > 0 && g0[c] && first_m0 < 0) first_m0 = c;
        end
        chk("lock_abort_count", 32'(n_ab), 32'd1);
        chk("lock_abort_cycle", 32'(ab_idx), 32'd17);
        chk("lock_starve", 32'(starve), 32'd16);
        chk("lock_m0_after", 32'(first_m0), 32'd18);
        chk("no_relock", 32'({g1[23], g0[22], g1[21], g0[20], g1[19]}), 32'b11111);
        chk("relock_take", 32'({g0[24], g1[25]}), 32'b11);
        chk("relock_hold", 32'({g0[26], g0[27], g0[28], g0[29]}), 32'b0000);
        chk("unlock_nogrant", 32'({g0[30], g1[30]}), 32'b00);
        chk("unlock_m0", 32'(g0[31]), 32'h1);

        // reset right after a read grant: response dropped, outputs held at 0
        do_reset(2);
        m0_req = 1; m0_addr = 32'h14;
        @(negedge CLK);
        chk("mid_gnt", 32'(m0_gnt), 32'h1);
        tick();
        RST_N = 0; m1_req = 1; rv_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            rv_cnt += int'(m0_rvalid);
            chk("mid_rst_out", 32'({m0_gnt, m1_gnt, ram_en, lock_abort}), 32'h0);
            tick();
        end
        RST_N = 1;
        @(negedge CLK);
        rv_cnt += int'(m0_rvalid);
        chk("post_rst_tie", 32'({m1_gnt, m0_gnt}), 32'b01);
        tick();
        idle_inputs();
        @(negedge CLK);
        chk("mid_no_stale", 32'(rv_cnt), 32'h0);
        tick();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nn_mem_arbiter.md
Name: nn_mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port, word-addressed data RAM.
- Requester 0 is the CPU load/store port; requester 1 is a loader/DMA or VGA fetch engine.
- Uses round-robin arbitration, an optional bounded bus lock for requester 1, and range checking with an error response.
- Sits between the requesters and the RAM macro, which has a 1-cycle registered read.

Parameters:
- RAM_WORDS, 1024, number of 32-bit words in RAM.
- AW, 10, RAM word-address width; must equal clog2(RAM_WORDS).
- LOCK_MAX, 16, maximum cycles requester 1 may hold the lock before forced release.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- m0_req  in  1  requester 0 access request; held stable until m0_gnt.
- m0_we  in  1  requester 0 write (1) / read (0).
- m0_addr  in  32  requester 0 byte address.
- m0_wdata  in  32  requester 0 write data.
- m0_gnt  out  1  requester 0 accepted this cycle (combinational).
- m0_rvalid  out  1  requester 0 response, 1 cycle after grant.
- m0_rdata  out  32  requester 0 read data, valid with m0_rvalid.
- m0_err  out  1  requester 0 response error, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0_* for requester 1.
- m1_lock  in  1  requester 1 requests exclusive back-to-back ownership.
- lock_abort  out  1  1-cycle pulse when a lock is force-released.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - state=ARB, last_gnt=1 (so M0 wins the first tie), lock_cnt=0, lock_armed=1.
  - Pending responses are discarded.
  - While RST_N=0, all gnt, ram_en, ram_we, rvalid, err and lock_abort are forced to 0; rdata outputs are 0.
- Request rules:
  - At most one grant per cycle.
  - A grant drives ram_en/ram_we/ram_addr/ram_wdata combinationally in the same cycle.
  - Throughput is 1 access/cycle; back-to-back grants are allowed.
- ARB state:
  - Only one req: grant it.
  - Both req: grant the requester not equal to last_gnt.
  - last_gnt updates on every grant.
- Address check:
  - Legal iff addr[1:0]==0 and addr[31:2] < RAM_WORDS.
  - Legal access: ram_addr=addr[AW+1:2].
  - Illegal access: still granted, but ram_en=0 and any write is dropped.
- Response, registered 1 cycle after the grant:
  - mX_rvalid=1 for exactly one cycle, for both reads and writes.
  - Legal read: mX_rdata=ram_rdata, err=0.
  - Write: rdata=0, err=0.
  - Illegal access: rdata=0, err=1.
  - The non-responding requester sees rdata=0.
- Lock:
  - ARB→LOCKED when M1 is granted with m1_lock=1 and lock_armed=1; lock_cnt is cleared.
  - In LOCKED, m0_gnt=0, M1 is granted whenever m1_req=1, and lock_cnt increments every cycle.
  - LOCKED→ARB when m1_lock=0. No grant is issued in that cycle.
  - LOCKED→ARB when lock_cnt==LOCK_MAX-1. This forced release also:
    - pulses lock_abort in the transition cycle;
    - sets last_gnt=1 so M0 wins the next tie;
    - clears lock_armed.
  - lock_armed re-sets only after m1_lock is observed 0 for at least one cycle.
  - While lock_armed=0, m1_lock is ignored and M1 arbitrates normally.
- Simultaneous events:
  - A write followed by a read to the same word on the next cycle returns the new data (RAM semantics).
  - A read response and a new grant to the same requester in the same cycle are legal.
- Reset mid-operation: a response due in the cycle after reset deassertion is suppressed.

Test Plan:
- M0 reads word 5 (addr 0x14, RAM[5]=0xDEADBEEF) → m0_gnt in cycle t, ram_addr=5, m0_rvalid=1 with rdata 0xDEADBEEF in t+1, m0_err=0.
- Both requesters issue continuous reads after reset → grants M0, M1, M0, M1…; no cycle with two grants.
- M1 writes 0x1234 to addr 0x40 then M0 reads 0x40 → ram_we=1, ram_addr=16; M0 later reads 0x00001234.
- M0 accesses addr 0x80000004 and addr 0x2 → granted, ram_en=0, m0_rvalid=1, m0_err=1, m0_rdata=0; the RAM word is unchanged.
- M1 holds m1_lock=1 and m1_req=1 with M0 also requesting, LOCK_MAX=16 → M0 starved exactly 16 cycles, lock_abort pulses once, M0 granted next cycle; lock is not re-taken until m1_lock drops for one cycle.
- RST_N asserted the cycle after an M0 read grant → no m0_rvalid afterwards; all outputs 0 during reset; the first post-reset tie goes to M0.
